// File: rtl/result_display_driver.sv
// Signed result -> BCD (sequential double-dabble) -> 4-digit multiplexed seven-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros and floats the minus sign.
module result_display_driver #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned REFRESH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] result,
  input  logic             result_valid,
  input  logic             div_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       finalToDisplay,
  output logic [3:0]       enable
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [7:0] SegMinus = 8'hBF;
  localparam logic [7:0] SegE     = 8'h86;
  localparam logic [7:0] SegR     = 8'hAF;
  localparam logic [7:0] SegBlank = 8'hFF;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        res_q, res_d;
  logic                    derr_q, derr_d;
  logic [WIDTH-1:0]        sh_q, sh_d;
  logic [19:0]             bcd_q, bcd_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic                    perr_q, perr_d;
  logic [15:0]             disp_q, disp_d;
  logic                    dneg_q, dneg_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  logic [1:0]              idx_q, idx_d;
  logic [3:0]              en_q, en_d;
  logic [7:0]              seg_q, seg_d;

  logic [WIDTH:0]          res_ext, mag_w;
  logic                    too_big;
  logic [19:0]             bcd_adj;
  logic [3:0][7:0]         codes;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = SegBlank;
    endcase
  endfunction

  // Per-digit segment codes from the committed display registers.
`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;
  always_comb begin
    codes = {4{SegBlank}};
    msd   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (disp_q[4*i+:4] != 4'd0) msd = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      codes[i] = (2'(i) > msd) ? SegBlank : seg7(disp_q[4*i+:4]);
    end
    if (dneg_q && msd != 2'd3) codes[msd + 2'd1] = SegMinus;
    if (err_q) codes = {SegE, SegR, SegR, SegBlank};
  end
`else
  always_comb begin
    codes = {4{SegBlank}};
    for (int i = 0; i < 4; i++) begin
      codes[i] = seg7(disp_q[4*i+:4]);
    end
    if (dneg_q) codes[3] = SegMinus;
    if (err_q) codes = {SegE, SegR, SegR, SegBlank};
  end
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    derr_d  = derr_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    perr_d  = perr_q;
    disp_d  = disp_q;
    dneg_d  = dneg_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // WIDTH+1 bits so the most negative input has a representable magnitude.
    res_ext = {res_q[WIDTH-1], res_q};
    mag_w   = res_ext[WIDTH] ? (~res_ext + 1'b1) : res_ext;
    too_big = res_ext[WIDTH] ? (32'(mag_w) > 32'd999) : (32'(mag_w) > 32'd9999);

    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    end

    case (state_q)
      StLoad: begin
        neg_d = res_q[WIDTH-1];
        if (derr_q || too_big) begin
          perr_d  = 1'b1;
          state_d = StCommit;
        end else begin
          perr_d  = 1'b0;
          bcd_d   = '0;
          sh_d    = mag_w[WIDTH-1:0];
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[18:0], sh_q[WIDTH-1]};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StCommit;
      end
      StCommit: begin
        disp_d  = bcd_q[15:0];
        dneg_d  = neg_q;
        err_d   = perr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: ;
    endcase

    // A new result always wins, even over an in-flight conversion; a commit still completes.
    if (result_valid) begin
      res_d   = result;
      derr_d  = div_err;
      busy_d  = 1'b1;
      state_d = StLoad;
    end

    presc_d = presc_q + 1'b1;
    idx_d   = (presc_q == '1) ? idx_q + 2'd1 : idx_q;
    en_d    = ~(4'b0001 << idx_d);
    seg_d   = codes[idx_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      res_q   <= '0;
      derr_q  <= 1'b0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      perr_q  <= 1'b0;
      disp_q  <= '0;
      dneg_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= 2'd0;
      en_q    <= 4'b1110;
      seg_q   <= 8'hC0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      derr_q  <= derr_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      perr_q  <= perr_d;
      disp_q  <= disp_d;
      dneg_q  <= dneg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign finalToDisplay = seg_q;
  assign enable         = en_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver: a scoreboard queue holds expected display
// contents and latency per conversion, popped and compared when done pulses.
module tb_result_display_driver;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             div_err;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       finalToDisplay;
  logic [3:0]       enable;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] segs;
    logic        e;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  result_display_driver #(
    .WIDTH       (WIDTH),
    .REFRESH_BITS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .result        (result),
    .result_valid  (result_valid),
    .div_err       (div_err),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .finalToDisplay(finalToDisplay),
    .enable        (enable)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] seg_tbl(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic bit model_err(input int v, input bit de);
    return de || (v > 9999) || (v < -999);
  endfunction

  // Returns {digit3, digit2, digit1, digit0}.
  function automatic logic [31:0] model_disp(input int v, input bit de);
    int         mag;
    int         dig[4];
    logic [7:0] c[4];
    int         top;
    if (model_err(v, de)) return {8'h86, 8'hAF, 8'hAF, 8'hFF};
    mag = (v < 0) ? -v : v;
    for (int i = 0; i < 4; i++) begin
      dig[i] = mag % 10;
      mag    = mag / 10;
    end
    top = 0;
    for (int i = 1; i < 4; i++) if (dig[i] != 0) top = i;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 4; i++) c[i] = (i > top) ? 8'hFF : seg_tbl(dig[i]);
    if (v < 0) c[top+1] = 8'hBF;
`else
    for (int i = 0; i < 4; i++) c[i] = seg_tbl(dig[i]);
    if (v < 0) c[3] = 8'hBF;
`endif
    return {c[3], c[2], c[1], c[0]};
  endfunction

  // Leaves the bench at the negedge following the sampling edge (cycle 0).
  task automatic drive_valid(input int v, input bit de);
    @(negedge clk);
    result       = WIDTH'(v);
    div_err      = de;
    result_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_valid = 1'b0;
    div_err      = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic read_disp(output logic [31:0] segs);
    logic [3:0] want;
    bit         found;
    segs = '1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      want  = 4'(~(4'b0001 << i));
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
        @(negedge clk);
        if (enable === want) begin
          segs[8*i+:8] = finalToDisplay;
          found        = 1'b1;
        end
      end
      check("scan_found", {31'd0, found}, 32'd1);
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  task automatic push_exp(input int v, input bit de, input string tag);
    exp_t e;
    e.segs = model_disp(v, de);
    e.e    = model_err(v, de);
    e.lat  = e.e ? 2 : WIDTH + 2;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic finish_conv();
    int          lat;
    logic [31:0] segs;
    exp_t        e;
    wait_done(lat);
    e = sb.pop_front();
    check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({e.tag, "_err"}, {31'd0, err}, {31'd0, e.e});
    @(posedge clk);
    @(negedge clk);
    check({e.tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({e.tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
    read_disp(segs);
    check({e.tag, "_digits"}, segs, e.segs);
  endtask

  task automatic convert(input int v, input bit de, input string tag);
    push_exp(v, de, tag);
    drive_valid(v, de);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    finish_conv();
  endtask

  initial begin
    int pulses;
    logic [31:0] segs;
    rst          = 1'b0;
    result       = '0;
    result_valid = 1'b0;
    div_err      = 1'b0;
    #4;
    rst = 1'b1;

    check("reset_enable", {28'd0, enable}, {28'd0, 4'b1110});
    check("reset_seg", {24'd0, finalToDisplay}, 32'h0000_00C0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan_1", {28'd0, enable}, {28'd0, 4'b1101});
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan_2", {28'd0, enable}, {28'd0, 4'b1011});
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan_3", {28'd0, enable}, {28'd0, 4'b0111});
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scan_0", {28'd0, enable}, {28'd0, 4'b1110});

    convert(9801, 1'b0, "pos_9801");
    convert(-66, 1'b0, "neg_66");
    convert(5, 1'b1, "div_err");
    convert(9999, 1'b0, "pos_max");
    convert(-999, 1'b0, "neg_max");
    convert(10000, 1'b0, "pos_ovf");
    convert(-1000, 1'b0, "neg_ovf");
    convert(-32768, 1'b0, "most_neg");
    convert(0, 1'b0, "zero");
    convert(-7, 1'b0, "neg_7");

    // Restart: the second value aborts the first; one done, timed from the second.
    drive_valid(9801, 1'b0);
    repeat (4) @(posedge clk);
    push_exp(1, 1'b0, "restart");
    drive_valid(1, 1'b0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    finish_conv();
    count_done(30, pulses);
    check("restart_no_extra_done", 32'(pulses), 32'd0);

    // Reset mid-conversion.
    drive_valid(9801, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_enable", {28'd0, enable}, {28'd0, 4'b1110});
    check("rst_mid_seg", {24'd0, finalToDisplay}, 32'h0000_00C0);
    rst = 1'b1;
    count_done(30, pulses);
    check("rst_mid_no_done", 32'(pulses), 32'd0);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    read_disp(segs);
    check("rst_mid_digits", segs, 32'hC0C0_C0C0);
    convert(1234, 1'b0, "after_rst");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/result_display_driver.md
Name: result_display_driver

Overview:
- Downstream stage of the calculator core: takes each signed binary result the core produces, plus its divide-by-zero flag.
- Converts the result to BCD with a sequential double-dabble engine.
- Time-multiplexes the 4-digit common-anode seven-segment display through finalToDisplay/enable.
- Previous digits stay on the display until a new conversion commits atomically.

Parameters:
WIDTH, 16, width of signed two's-complement result input
REFRESH_BITS, 2, width of the refresh prescaler; digit advances every 2^REFRESH_BITS clocks (small default for simulation)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
result  input  WIDTH  signed result from calculator core
result_valid  input  1  single-cycle strobe; result/div_err sampled on this edge
div_err  input  1  divide-by-zero flag, qualified by result_valid
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when new digits are committed
err  output  1  display currently shows error (div_err or overflow)
finalToDisplay  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
enable  output  4  digit anodes, active-low one-hot; bit0 = rightmost

Behaviour:
- Reset (rst=0, async) values:
  - busy=0, done=0, err=0; committed digits = "0000", positive.
  - Refresh counter=0, digit index=0, enable=4'b1110, finalToDisplay=8'hC0.
- Segment codes:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
  - minus:BF, E:86, r:AF, blank:FF.
  - dp is always 1 (off).
- States: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE: on result_valid, capture result and div_err, go to LOAD; busy=1 from the next cycle.
  - LOAD: sign = MSB; magnitude = |result| in WIDTH+1 bits, so -2^(WIDTH-1) is representable.
    - Error if div_err=1, or positive magnitude > 9999, or negative magnitude > 999; error goes straight to COMMIT.
    - Otherwise clear the 20-bit BCD accumulator, shift counter = WIDTH, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,mag} left by 1. After WIDTH cycles go to COMMIT.
  - COMMIT: latch the 4 low BCD digits, sign and err into display registers; done=1 for this cycle; busy=0 next cycle; return to IDLE.
- Latency, counting the result_valid edge as cycle 0:
  - Normal: done asserts in cycle WIDTH+2 (18 with default).
  - Error: done asserts in cycle 2.
- Restart: result_valid in any non-IDLE state aborts the current conversion and reloads (latest wins). Only one done pulse is produced, for the last value.
- Simultaneous result_valid and COMMIT: the commit completes, and the new value is captured to LOAD in the same cycle.
- Display composition (macro off):
  - Negative: digit3 = minus, digits2..0 = magnitude.
  - Positive: digits3..0 = magnitude.
  - err: digit3=E, digit2=r, digit1=r, digit0=blank.
- Refresh scan:
  - Prescaler increments every clock.
  - On wrap, the digit index advances 0,1,2,3,0.
  - enable and finalToDisplay are registered and change on the same edge.
  - Scanning never stops, including while busy.
- Reset asserted mid-conversion: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits above the most significant nonzero digit are blanked; digit0 is never blanked.
  - For negatives, the minus sign sits immediately left of the most significant nonzero digit. Example: -66 shows " -66" instead of "-066".
- Undefined: all four digits are shown, minus fixed at digit3.

Test Plan:
1. rst=0 for 4 ns then 1, no valid -> enable=1110, finalToDisplay=C0, busy=0; enable cycles 1110,1101,1011,0111 every 4 clocks.
2. result=9801, result_valid pulse -> done exactly 18 clocks later; then digit0=F9, digit1=C0, digit2=80, digit3=90; err=0.
3. result=-66 -> digits "-066" (BF,C0,82,82 from digit3 to digit0); with LEADING_ZERO_BLANK_EN: FF,BF,82,82.
4. div_err=1 with result_valid -> done 2 clocks later, err=1; digits 86,AF,AF,FF.
5. result=9801 valid, then result=1 valid 5 clocks later -> single done 18 clocks after second valid; display 0001 (C0,C0,C0,F9). Separately, result=10000 -> err=1, "Err ".
6. result=9801 valid, rst=0 at clock 8 -> busy=0, no done, display 0000; after release a new valid converts normally.
